sass_rx_hamming: RTL and testbench
==================================

Name: sass_rx_hamming

Overview:
Parametrised receiver for the single-wire SASS command line. It frames start/data/end bits at a programmable bit period, then Hamming-decodes and corrects a DATA_W-bit payload. Decoded words are delivered over a valid/ready interface, and errored frames are tracked over a sliding window of frames. It is the generalised successor of the fixed 14/10-bit receiver in the demo controller, and feeds the command/TMR logic upstream of speed and direction processing.

Parameters:
BIT_T, 5, clocks per SASS bit (>=3)
DATA_W, 10, payload bits
PAR_W, 4, Hamming parity bits; 2**PAR_W >= DATA_W+PAR_W+1 is required (elaboration error otherwise)
ERR_WIN, 16, frames per error-rate window (>=2)
MAX_ERR_RATE, 5, errored frames per window that declare the link bad

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset; all state clears on the clk edge where rst==0
s  in  1  SASS line; idle high, already synchronised upstream
data_o  out  DATA_W  decoded, corrected payload
valid_o  out  1  data_o holds an undelivered word
ready_i  in  1  consumer accepts data_o when valid_o&&ready_i
corrected_o  out  1  qualifies data_o: a single-bit fix was applied
err_p  out  1  1-cycle pulse: uncorrectable or framing error; frame discarded
ovr_p  out  1  1-cycle pulse: a good frame was dropped because the output was full
link_bad_o  out  1  error rate at or above the threshold in the last complete window
state_o  out  2  FSM state probe

Behaviour:
- CODE_W = DATA_W+PAR_W (localparam); codeword position j (1-based) = code[j-1].
- Parity bits sit at the power-of-two positions. Parity k is the XOR of all positions with bit k set. Data bits fill the remaining positions in ascending order, so the default codeword is {d9..d4,p3,d3,d2,d1,p2,d0,p1,p0}.
- Frame on the wire: start 0, then code[0]..code[CODE_W-1] LSB first, then end bit 0, then line back to 1.
- FSM states (state_o): ARM=0, IDLE=1, DATA=2, STOP=3.
  - ARM: wait until s==1 for BIT_T consecutive clocks, then go to IDLE. Reset enters ARM, so a line held low at reset is not taken as a start bit.
  - IDLE: on s==0, load the bit counter and go to DATA. At the mid-point (floor(BIT_T/2) clocks), re-check the start bit. If s==1, it was a glitch: go back to IDLE with no error.
  - DATA: sample at each bit mid-point, BIT_T clocks apart; shift in CODE_W bits, then go to STOP.
  - STOP: sample at mid-point. s==0 means a valid frame. s==1 is a framing error: err_p fires. Either way, go to ARM.
- Decode is registered. Syndrome = XOR of the indices of set bits.
  - Syndrome 0: clean.
  - 1<=syn<=CODE_W: flip code[syn-1] and set corrected.
  - syn>CODE_W: uncorrectable; err_p fires.
- Latency: data_o/valid_o update 1 clock after the end-bit sample.
- Output holding register:
  - valid_o falls on the cycle after a handshake.
  - A new good frame arriving while valid_o&&!ready_i is dropped, ovr_p fires, and the old word is kept.
  - If the handshake and the new word land on the same cycle, the new word is loaded and no ovr_p fires.
- Error window: every finished frame (good, corrected, or errored) increments frame_cnt. Corrected or errored frames also increment err_cnt, saturating at ERR_WIN. When frame_cnt reaches ERR_WIN:
  - link_bad_o <= (err_cnt_next >= MAX_ERR_RATE);
  - both counters clear.
  Overrun does not count as an error.
- Reset values: data_o=0, valid_o=0, corrected_o=0, err_p=0, ovr_p=0, link_bad_o=0, state_o=ARM, all counters 0.
- rst low mid-frame abandons the partial frame silently; no pulses fire.

Optional Feature:
SASS_SECDED_EN:
- When defined, an overall parity bit (even parity over code[0..CODE_W-1]) is sent after code[CODE_W-1], so the frame has CODE_W+1 payload bits.
- Nonzero syndrome with overall parity failing: corrected single error.
- Nonzero syndrome with overall parity passing: double error; err_p fires.
- Zero syndrome with overall parity failing: the parity bit itself was hit; data accepted with corrected_o=1.
- When not defined, plain SEC as described above; double errors may be miscorrected.

Decomposition:
- sass_pkg holds:
  - state encodings ARM/IDLE/DATA/STOP;
  - function code_w(DATA_W) returning the minimum PAR_W;
  - function is_pow2;
  - function hamming_syndrome;
  - function extract_data (strips parity positions).
- One sub-module, sass_bit_timer: it counts BIT_T, asserts mid_p and bit_p, and restarts on load. The FSM, decoder and output/window logic stay in the top module.

Test Plan:
1. Reset, then line held high for 5 clocks, then payload 10'h044 sent as codeword 14'h04A9 -> data_o=10'h044, valid_o high 1 clk after the end bit, corrected_o=0.
2. Same frame with code[6] flipped (14'h04E9) -> data_o=10'h044, corrected_o=1; no err_p.
3. End bit driven 1 -> err_p pulse, no valid_o, state_o returns to ARM.
4. ready_i held low while two good frames (10'h044 then 10'h111) arrive -> second dropped, ovr_p once, data_o stays 10'h044. Then ready_i high, handshake, valid_o low next clk.
5. 16 frames of which 5 carry a single-bit error -> link_bad_o=1 after the 16th. Next 16 frames clean -> link_bad_o=0.
6. s held low through reset, then a 2-clock low glitch after arming -> no frame and no err_p. rst pulsed low mid-DATA -> no output and no pulses, FSM in ARM.

Source files
------------

// File: rtl/sass_pkg.sv
// sass_pkg: shared types and Hamming helpers for the SASS receiver.
//   sass_state_e      FSM encodings ARM/IDLE/DATA/STOP (also the state_o probe value)
//   code_w()          minimum parity-bit count for a given payload width
//   is_pow2()         true for the parity positions of a codeword
//   hamming_syndrome  XOR of the 1-based indices of all set codeword bits
//   extract_data      strips parity positions, packing data bits LSB first
`timescale 1ns/1ps
package sass_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } sass_state_e;

  // Helpers operate on a fixed-width container; callers cast in and out.
  localparam int unsigned MAX_CODE_W = 64;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned SYN_W      = 8;

  function automatic int unsigned code_w(int unsigned data_w);
    int unsigned p;
    logic        found;
    p     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && ((64'd1 << i) >= (64'(data_w) + 64'(i) + 64'd1))) begin
        p     = i;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic is_pow2(int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic logic [SYN_W-1:0] hamming_syndrome(logic [MAX_CODE_W-1:0] code,
                                                         int unsigned n);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int unsigned j = 1; j <= MAX_CODE_W; j++) begin
      if ((j <= n) && code[IDX_W'(j - 1)]) syn = syn ^ SYN_W'(j);
    end
    return syn;
  endfunction

  function automatic logic [MAX_CODE_W-1:0] extract_data(logic [MAX_CODE_W-1:0] code,
                                                          int unsigned n);
    logic [MAX_CODE_W-1:0] d;
    int unsigned           k;
    d = '0;
    k = 0;
    for (int unsigned j = 1; j <= MAX_CODE_W; j++) begin
      if ((j <= n) && !is_pow2(j)) begin
        d[IDX_W'(k)] = code[IDX_W'(j - 1)];
        k            = k + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/sass_bit_timer.sv
// sass_bit_timer: free-running BIT_T clock counter for SASS bit framing.
//   clk, rst   clock, synchronous active-low reset
//   i_load     restart the count (cycle of the load edge is clock 0)
//   o_mid_p    registered pulse; the following edge is a bit mid-point
//   o_bit_p    registered pulse; the following edge closes a full bit period
`timescale 1ns/1ps
module sass_bit_timer #(
  parameter int unsigned BIT_T = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_mid_p,
  output logic o_bit_p
);

  localparam int unsigned CNT_W = $clog2(BIT_T);
  localparam int unsigned HALF  = BIT_T / 2;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_mid_p;
  logic             r_bit_p;

  // Next count: restart on load, wrap at the end of a bit period.
  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (i_load || (r_cnt == CNT_W'(BIT_T - 1))) w_cnt_nxt = '0;
  end

  // Pulses are decoded from the next count so they line up with the edge after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_mid_p <= 1'b0;
      r_bit_p <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_mid_p <= (w_cnt_nxt == CNT_W'(HALF - 1));
      r_bit_p <= (w_cnt_nxt == CNT_W'(BIT_T - 1));
    end
  end

  assign o_mid_p = r_mid_p;
  assign o_bit_p = r_bit_p;

endmodule

// File: rtl/sass_rx_hamming.sv
// sass_rx_hamming: SASS single-wire receiver with Hamming SEC decode,
// valid/ready output holding register and windowed link-quality monitor.
//   clk, rst        clock, synchronous active-low reset
//   s               SASS line (idle high, pre-synchronised)
//   data_o          decoded, corrected payload         valid_o / ready_i  handshake
//   corrected_o     a single-bit fix was applied       err_p   uncorrectable/framing pulse
//   ovr_p           good frame dropped, output full    link_bad_o  window error rate too high
//   state_o         FSM state probe (ARM=0 IDLE=1 DATA=2 STOP=3)
// Build option: SASS_SECDED_EN appends an overall even-parity bit for SECDED.
`timescale 1ns/1ps
module sass_rx_hamming
  import sass_pkg::*;
#(
  parameter int unsigned BIT_T        = 5,
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned PAR_W        = 4,
  parameter int unsigned ERR_WIN      = 16,
  parameter int unsigned MAX_ERR_RATE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              corrected_o,
  output logic              err_p,
  output logic              ovr_p,
  output logic              link_bad_o,
  output logic [1:0]        state_o
);

  localparam int unsigned CODE_W = DATA_W + PAR_W;
`ifdef SASS_SECDED_EN
  localparam int unsigned NBITS  = CODE_W + 1;
`else
  localparam int unsigned NBITS  = CODE_W;
`endif
  localparam int unsigned BIDX_W = $clog2(NBITS + 1);
  localparam int unsigned WCNT_W = $clog2(ERR_WIN + 1);

  if (PAR_W < code_w(DATA_W)) begin : g_bad_par
    $error("sass_rx_hamming: PAR_W too small for DATA_W");
  end
  if (CODE_W > MAX_CODE_W) begin : g_bad_width
    $error("sass_rx_hamming: codeword wider than helper container");
  end

  sass_state_e       r_state, w_state_nxt;
  logic [BIDX_W-1:0] r_idx, w_idx_nxt;
  logic [NBITS-1:0]  r_shift, w_shift_nxt;
  logic              w_load, w_stop_ok, w_stop_bad;
  logic              w_mid_p, w_bit_p;

  sass_bit_timer #(.BIT_T(BIT_T)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .o_mid_p (w_mid_p),
    .o_bit_p (w_bit_p)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_ARM;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Framing FSM. r_idx==0 is the start-bit re-check; 1..NBITS are payload bits.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_ARM: begin
        // Any low restarts the high-time count.
        if (!s) w_load = 1'b1;
        else if (w_bit_p) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!s) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_mid_p) begin
          if (r_idx == '0) begin
            if (s) w_state_nxt = ST_IDLE;
            else   w_idx_nxt   = BIDX_W'(1);
          end else begin
            w_shift_nxt = {s, r_shift[NBITS-1:1]};
            w_idx_nxt   = r_idx + BIDX_W'(1);
            if (r_idx == BIDX_W'(NBITS)) w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_mid_p) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ARM;
          if (!s) w_stop_ok  = 1'b1;
          else    w_stop_bad = 1'b1;
        end
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // Hamming decode of the shifted-in codeword (stable while in STOP).
  logic [CODE_W-1:0] w_code, w_mask, w_fixed;
  logic [PAR_W-1:0]  w_syn;
  logic [DATA_W-1:0] w_data;
  logic              w_corr, w_unc, w_in_range;

  assign w_code = r_shift[CODE_W-1:0];
  assign w_syn  = PAR_W'(hamming_syndrome(MAX_CODE_W'(w_code), CODE_W));

  for (genvar j = 1; j <= CODE_W; j++) begin : g_flip
    assign w_mask[j-1] = (w_syn == PAR_W'(j));
  end

  assign w_fixed    = w_code ^ w_mask;
  assign w_in_range = |w_mask;
  assign w_data     = DATA_W'(extract_data(MAX_CODE_W'(w_fixed), CODE_W));

`ifdef SASS_SECDED_EN
  logic w_par_fail;
  assign w_par_fail = ^r_shift;
  // Parity failing means an odd error count; zero syndrome then blames the parity bit.
  always_comb begin
    w_corr = 1'b0;
    w_unc  = 1'b0;
    if (w_syn != '0) begin
      if (w_par_fail && w_in_range) w_corr = 1'b1;
      else                          w_unc  = 1'b1;
    end else if (w_par_fail) begin
      w_corr = 1'b1;
    end
  end
`else
  always_comb begin
    w_corr = w_in_range;
    w_unc  = (w_syn != '0) && !w_in_range;
  end
`endif

  // Decode stage registered at the end-bit sample.
  logic              r_done, r_good, r_corr;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_good <= 1'b0;
      r_corr <= 1'b0;
      r_data <= '0;
    end else begin
      r_done <= w_stop_ok || w_stop_bad;
      r_good <= w_stop_ok && !w_unc;
      if (w_stop_ok) begin
        r_corr <= w_corr;
        r_data <= w_data;
      end
    end
  end

  // Output holding register; a simultaneous handshake frees the slot for the new word.
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_out_corr, r_err_p, r_ovr_p;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_corr  <= 1'b0;
      r_err_p     <= 1'b0;
      r_ovr_p     <= 1'b0;
    end else begin
      r_err_p <= r_done && !r_good;
      r_ovr_p <= 1'b0;
      if (r_good) begin
        if (!r_out_valid || ready_i) begin
          r_out_data  <= r_data;
          r_out_corr  <= r_corr;
          r_out_valid <= 1'b1;
        end else begin
          r_ovr_p <= 1'b1;
        end
      end else if (r_out_valid && ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Sliding window of finished frames; overruns are not link errors.
  logic [WCNT_W-1:0] r_frm_cnt, r_err_cnt, w_frm_cnt_nxt, w_err_cnt_nxt;
  logic              r_link_bad, w_err_evt;

  always_comb begin
    w_err_evt     = r_done && (!r_good || r_corr);
    w_frm_cnt_nxt = r_frm_cnt + WCNT_W'(1);
    w_err_cnt_nxt = r_err_cnt;
    if (w_err_evt && (r_err_cnt != WCNT_W'(ERR_WIN))) w_err_cnt_nxt = r_err_cnt + WCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frm_cnt  <= '0;
      r_err_cnt  <= '0;
      r_link_bad <= 1'b0;
    end else if (r_done) begin
      if (w_frm_cnt_nxt == WCNT_W'(ERR_WIN)) begin
        r_link_bad <= (32'(w_err_cnt_nxt) >= MAX_ERR_RATE);
        r_frm_cnt  <= '0;
        r_err_cnt  <= '0;
      end else begin
        r_frm_cnt <= w_frm_cnt_nxt;
        r_err_cnt <= w_err_cnt_nxt;
      end
    end
  end

  assign data_o      = r_out_data;
  assign valid_o     = r_out_valid;
  assign corrected_o = r_out_corr;
  assign err_p       = r_err_p;
  assign ovr_p       = r_ovr_p;
  assign link_bad_o  = r_link_bad;
  assign state_o     = r_state;

endmodule

// File: tb/tb_sass_rx_hamming.sv
// tb_sass_rx_hamming: scoreboard bench for sass_rx_hamming (default parameters).
`timescale 1ns/1ps
module tb_sass_rx_hamming;

  localparam int BIT_T   = 5;
  localparam int DATA_W  = 10;
  localparam int PAR_W   = 4;
  localparam int CODE_W  = 14;
  localparam int ERR_WIN = 16;
  localparam int GAP     = 3 * BIT_T;

  logic              clk = 1'b0;
  logic              rst, s, ready_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o, corrected_o, err_p, ovr_p, link_bad_o;
  logic [1:0]        state_o;

  always #5 clk = ~clk;

  sass_rx_hamming dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .corrected_o (corrected_o),
    .err_p       (err_p),
    .ovr_p       (ovr_p),
    .link_bad_o  (link_bad_o),
    .state_o     (state_o)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_err_p  = 0;
  int   n_ovr_p  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Independent encoder: data in non-power-of-two positions, parity k over positions with bit k set.
  function automatic logic [CODE_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int                k;
    logic              b;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int p = 0; p < PAR_W; p++) begin
      b = 1'b0;
      for (int pos = 1; pos <= CODE_W; pos++) if (((pos >> p) & 1) != 0) b ^= c[pos-1];
      c[(1 << p) - 1] = b;
    end
    return c;
  endfunction

  // Monitor: pulse counting and scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (err_p) n_err_p++;
      if (ovr_p) n_ovr_p++;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("data_o", 32'(data_o), 32'(e.data));
          check_eq("corrected_o", 32'(corrected_o), 32'(e.corr));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    s = b;
    tick(BIT_T);
  endtask

  // Sends clean^mask; the overall parity (SECDED builds) always covers the clean word.
  task automatic send_frame(input logic [CODE_W-1:0] clean, input logic [CODE_W-1:0] mask,
                            input logic end_bit, input bit lat_chk);
    logic [CODE_W-1:0] tx;
    tx = clean ^ mask;
    send_bit(1'b0);
    for (int i = 0; i < CODE_W; i++) send_bit(tx[i]);
`ifdef SASS_SECDED_EN
    send_bit(^clean);
`endif
    s = end_bit;
    if (lat_chk) begin
      tick(BIT_T / 2 + 1);
      check_eq("valid_before_latency", 32'(valid_o), 32'd0);
      tick(1);
      check_eq("valid_after_latency", 32'(valid_o), 32'd1);
      tick(BIT_T - BIT_T / 2 - 2);
    end else begin
      tick(BIT_T);
    end
  endtask

  task automatic idle(input int n);
    s = 1'b1;
    tick(n);
  endtask

  // One error window: the first n_bad frames carry a single-bit error.
  task automatic window(input int n_bad, input logic exp_bad, input logic prev_bad);
    logic [DATA_W-1:0] d;
    logic [CODE_W-1:0] m;
    for (int i = 0; i < ERR_WIN; i++) begin
      d = DATA_W'($urandom_range(1023, 0));
      m = (i < n_bad) ? (CODE_W'(1) << (13 - 3 * i)) : '0;
      if (i == ERR_WIN - 1) check_eq("link_bad_mid_window", 32'(link_bad_o), 32'(prev_bad));
      sb.push_back('{data: d, corr: (i < n_bad)});
      send_frame(enc(d), m, 1'b0, 1'b0);
      idle(GAP);
    end
    check_eq("link_bad_window_end", 32'(link_bad_o), 32'(exp_bad));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    exp_err = 0;
    rst     = 1'b0;
    s       = 1'b0;
    ready_i = 1'b1;
    tick(4);
    check_eq("rst_data_o", 32'(data_o), 32'd0);
    check_eq("rst_valid_o", 32'(valid_o), 32'd0);
    check_eq("rst_corrected_o", 32'(corrected_o), 32'd0);
    check_eq("rst_err_p", 32'(err_p), 32'd0);
    check_eq("rst_ovr_p", 32'(ovr_p), 32'd0);
    check_eq("rst_link_bad", 32'(link_bad_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);

    // Line low out of reset must not look like a start bit.
    rst = 1'b1;
    tick(10);
    check_eq("arm_held_low", 32'(state_o), 32'd0);
    idle(BIT_T + 2);
    check_eq("armed_idle", 32'(state_o), 32'd1);

    // Clean frame with latency check.
    sb.push_back('{data: 10'h044, corr: 1'b0});
    send_frame(14'h04A9, '0, 1'b0, 1'b1);
    idle(GAP);

    // Single-bit error at code[6].
    sb.push_back('{data: 10'h044, corr: 1'b1});
    send_frame(14'h04A9, 14'h0040, 1'b0, 1'b0);
    idle(GAP);
    check_eq("no_err_on_corrected", 32'(n_err_p), 32'(exp_err));

    // Framing error: end bit high.
    send_frame(enc(10'h2A5), '0, 1'b1, 1'b0);
    check_eq("ferr_state_arm", 32'(state_o), 32'd0);
    idle(GAP);
    exp_err++;
    check_eq("ferr_err_p", 32'(n_err_p), 32'(exp_err));
    check_eq("ferr_no_valid", 32'(valid_o), 32'd0);

    // Syndrome 15 is out of range: uncorrectable.
    send_frame(14'h04A9, 14'h2001, 1'b0, 1'b0);
    idle(GAP);
    exp_err++;
    check_eq("unc_err_p", 32'(n_err_p), 32'(exp_err));

    // Overrun with ready low.
    ready_i = 1'b0;
    sb.push_back('{data: 10'h044, corr: 1'b0});
    send_frame(enc(10'h044), '0, 1'b0, 1'b0);
    idle(GAP);
    send_frame(enc(10'h111), '0, 1'b0, 1'b0);
    idle(GAP);
    check_eq("ovr_count", 32'(n_ovr_p), 32'd1);
    check_eq("ovr_data_kept", 32'(data_o), 32'h044);
    check_eq("ovr_valid_held", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    tick(1);
    check_eq("valid_drop_after_hs", 32'(valid_o), 32'd0);

    // Fresh windows from reset.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    idle(BIT_T + 3);
    window(4, 1'b0, 1'b0);
    window(5, 1'b1, 1'b0);
    window(0, 1'b0, 1'b1);
    check_eq("window_no_err_p", 32'(n_err_p), 32'(exp_err));

    // Two-clock start glitch.
    s = 1'b0;
    tick(2);
    idle(GAP);
    check_eq("glitch_state_idle", 32'(state_o), 32'd1);
    check_eq("glitch_no_err", 32'(n_err_p), 32'(exp_err));

    // Reset mid-DATA abandons the frame silently.
    s = 1'b0;
    tick(4 * BIT_T);
    check_eq("mid_frame_in_data", 32'(state_o), 32'd2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check_eq("mid_rst_state_arm", 32'(state_o), 32'd0);
    idle(6 * BIT_T);
    check_eq("mid_rst_no_err", 32'(n_err_p), 32'(exp_err));
    check_eq("mid_rst_no_ovr", 32'(n_ovr_p), 32'd1);
    check_eq("mid_rst_no_valid", 32'(valid_o), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
